// File: rtl/vita_sync_encoder.sv
// Sync-channel and four-lane data encoder for a VITA-style parallel sensor link.
// Emits FS/LS, IMG kernels, a per-line XOR checksum, FE/LE and blanking for each frame.
module vita_sync_encoder #(
  parameter int unsigned KERNELS = 8,
  parameter int unsigned LINES   = 4,
  parameter int unsigned HBLANK  = 4,
  parameter int unsigned VBLANK  = 8
) (
  input  logic        par_clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        start,
  input  logic [31:0] pixel_data,
  output logic        pixel_ready,
  output logic [7:0]  sync,
  output logic [31:0] cam_d,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned CW = 16;

  localparam logic [7:0] SYNC_FS  = 8'b1010_1010;
  localparam logic [7:0] SYNC_FE  = 8'b1100_1010;
  localparam logic [7:0] SYNC_LS  = 8'b0010_1010;
  localparam logic [7:0] SYNC_LE  = 8'b0100_1010;
  localparam logic [7:0] SYNC_BL  = 8'b0000_0101;
  localparam logic [7:0] SYNC_IMG = 8'b0000_1101;
  localparam logic [7:0] SYNC_CRC = 8'b0001_0110;
  localparam logic [7:0] SYNC_TP  = 8'b1110_1001;

  // Terminal counts; HBLANK_LAST is only consulted when HBLANK is non-zero.
  localparam logic [CW-1:0] KERNEL_LAST = CW'(KERNELS - 1);
  localparam logic [CW-1:0] LINE_LAST   = CW'(LINES - 1);
  localparam logic [CW-1:0] HBLANK_LAST = CW'(HBLANK - 1);
  localparam logic [CW-1:0] VBLANK_LAST = CW'(VBLANK - 1);

  typedef enum logic [2:0] {
    IDLE,
    LSTART,
    IMG,
    CRC,
    LEND,
    HBLK,
    VBLK
  } state_t;

  state_t         state;
  logic [CW-1:0]  line_cnt;
  logic [CW-1:0]  kernel_cnt;
  logic [CW-1:0]  blank_cnt;
  logic [31:0]    csum;

  // Request the next kernel one cycle ahead of every IMG output cycle.
  assign pixel_ready = (state == LSTART) ||
                       ((state == IMG) && (kernel_cnt != KERNEL_LAST));

  always_ff @(posedge par_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      line_cnt   <= '0;
      kernel_cnt <= '0;
      blank_cnt  <= '0;
      csum       <= '0;
      sync       <= SYNC_TP;
      cam_d      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (start && enable) begin
            state    <= LSTART;
            line_cnt <= '0;
            csum     <= '0;
            busy     <= 1'b1;
            sync     <= SYNC_FS;
            cam_d    <= '0;
          end else begin
            sync  <= enable ? SYNC_TP : SYNC_BL;
            cam_d <= enable ? {4{SYNC_TP}} : 32'h0;
          end
        end

        // Accumulator restarts here: the first kernel replaces the old checksum.
        LSTART: begin
          state      <= IMG;
          kernel_cnt <= '0;
          csum       <= pixel_data;
          sync       <= SYNC_IMG;
          cam_d      <= pixel_data;
        end

        IMG: begin
          if (kernel_cnt == KERNEL_LAST) begin
            state <= CRC;
            sync  <= SYNC_CRC;
            cam_d <= csum;
          end else begin
            kernel_cnt <= kernel_cnt + 16'd1;
            csum       <= csum ^ pixel_data;
            sync       <= SYNC_IMG;
            cam_d      <= pixel_data;
          end
        end

        CRC: begin
          state <= LEND;
          sync  <= (line_cnt == LINE_LAST) ? SYNC_FE : SYNC_LE;
          cam_d <= '0;
        end

        LEND: begin
          cam_d     <= '0;
          blank_cnt <= '0;
          if (line_cnt == LINE_LAST) begin
            state      <= VBLK;
            sync       <= SYNC_BL;
            frame_done <= (VBLANK_LAST == '0);
          end else begin
            line_cnt <= line_cnt + 16'd1;
            if (HBLANK == 0) begin
              state <= LSTART;
              csum  <= '0;
              sync  <= SYNC_LS;
            end else begin
              state <= HBLK;
              sync  <= SYNC_BL;
            end
          end
        end

        HBLK: begin
          cam_d <= '0;
          if (blank_cnt == HBLANK_LAST) begin
            state <= LSTART;
            csum  <= '0;
            sync  <= SYNC_LS;
          end else begin
            blank_cnt <= blank_cnt + 16'd1;
            sync      <= SYNC_BL;
          end
        end

        // frame_done is raised on entry to the final blanking cycle.
        VBLK: begin
          if (blank_cnt == VBLANK_LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sync       <= enable ? SYNC_TP : SYNC_BL;
            cam_d      <= enable ? {4{SYNC_TP}} : 32'h0;
          end else begin
            blank_cnt  <= blank_cnt + 16'd1;
            frame_done <= ((blank_cnt + 16'd1) == VBLANK_LAST);
            sync       <= SYNC_BL;
            cam_d      <= '0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          sync  <= SYNC_TP;
          cam_d <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vita_sync_encoder.sv
// Scoreboard bench for vita_sync_encoder: default instance u0 plus a short-frame
// instance u1 (KERNELS=2, LINES=1, HBLANK=0, VBLANK=3).
module tb_vita_sync_encoder;

  localparam logic [7:0] FS  = 8'b1010_1010;
  localparam logic [7:0] FE  = 8'b1100_1010;
  localparam logic [7:0] LS  = 8'b0010_1010;
  localparam logic [7:0] LE  = 8'b0100_1010;
  localparam logic [7:0] BL  = 8'b0000_0101;
  localparam logic [7:0] IM  = 8'b0000_1101;
  localparam logic [7:0] CR  = 8'b0001_0110;
  localparam logic [7:0] TP  = 8'b1110_1001;

  localparam int K0 = 8;
  localparam int L0 = 4;
  localparam int H0 = 4;
  localparam int V0 = 8;

  typedef struct packed {
    logic [7:0]  s;
    logic [31:0] d;
    logic        b;
    logic        fd;
    logic        r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, st0, rdy0, busy0, fd0;
  logic        en1, st1, rdy1, busy1, fd1;
  logic [31:0] pix0, pix1, camd0, camd1;
  logic [7:0]  sync0, sync1;

  int checks   = 0;
  int failures = 0;
  int pcnt0    = 0;
  int pcnt1    = 0;
  int ecnt0    = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  vita_sync_encoder u0 (
    .par_clock(clk), .reset_n(rst_n), .enable(en0), .start(st0),
    .pixel_data(pix0), .pixel_ready(rdy0), .sync(sync0), .cam_d(camd0),
    .busy(busy0), .frame_done(fd0)
  );

  vita_sync_encoder #(.KERNELS(2), .LINES(1), .HBLANK(0), .VBLANK(3)) u1 (
    .par_clock(clk), .reset_n(rst_n), .enable(en1), .start(st1),
    .pixel_data(pix1), .pixel_ready(rdy1), .sync(sync1), .cam_d(camd1),
    .busy(busy1), .frame_done(fd1)
  );

  function automatic exp_t mk(logic [7:0] s, logic [31:0] d, logic b, logic fd, logic r);
    exp_t e;
    e.s = s; e.d = d; e.b = b; e.fd = fd; e.r = r;
    return e;
  endfunction

  function automatic exp_t idle(logic en);
    return mk(en ? TP : BL, en ? {4{TP}} : 32'h0, 1'b0, 1'b0, 1'b0);
  endfunction

  // First frame uses a plain counter; later kernels are scrambled so line checksums are non-trivial.
  function automatic logic [31:0] pv0(int n);
    logic [31:0] v;
    v = 32'(n);
    return (n < 32) ? v : v * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] pv1(int n);
    logic [31:0] v;
    v = 32'(n);
    if (n == 0) return 32'h1122_3344;
    if (n == 1) return 32'h0102_0304;
    return 32'hDEAD_0000 | v;
  endfunction

  task automatic chk(string nm, exp_t g, exp_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got sync=%h cam_d=%h busy=%b frame_done=%b pixel_ready=%b, want sync=%h cam_d=%h busy=%b frame_done=%b pixel_ready=%b",
               nm, g.s, g.d, g.b, g.fd, g.r, e.s, e.d, e.b, e.fd, e.r);
    end
  endtask

  // Expected output sequence of one default-parameter frame on u0.
  task automatic push_frame0();
    logic [31:0] x, v;
    for (int l = 0; l < L0; l++) begin
      q0.push_back(mk((l == 0) ? FS : LS, 32'h0, 1'b1, 1'b0, 1'b1));
      x = 32'h0;
      for (int k = 0; k < K0; k++) begin
        v = pv0(ecnt0);
        ecnt0++;
        x ^= v;
        q0.push_back(mk(IM, v, 1'b1, 1'b0, k < K0 - 1));
      end
      q0.push_back(mk(CR, x, 1'b1, 1'b0, 1'b0));
      q0.push_back(mk((l == L0 - 1) ? FE : LE, 32'h0, 1'b1, 1'b0, 1'b0));
      if (l < L0 - 1)
        for (int h = 0; h < H0; h++) q0.push_back(mk(BL, 32'h0, 1'b1, 1'b0, 1'b0));
    end
    for (int b = 0; b < V0; b++) q0.push_back(mk(BL, 32'h0, 1'b1, b == V0 - 1, 1'b0));
  endtask

  // Hand-computed short frame on u1: no LS/LE, checksum given directly.
  task automatic push_frame1(logic [31:0] d0, logic [31:0] d1, logic [31:0] crc);
    q1.push_back(mk(FS, 32'h0, 1'b1, 1'b0, 1'b1));
    q1.push_back(mk(IM, d0,    1'b1, 1'b0, 1'b1));
    q1.push_back(mk(IM, d1,    1'b1, 1'b0, 1'b0));
    q1.push_back(mk(CR, crc,   1'b1, 1'b0, 1'b0));
    q1.push_back(mk(FE, 32'h0, 1'b1, 1'b0, 1'b0));
    q1.push_back(mk(BL, 32'h0, 1'b1, 1'b0, 1'b0));
    q1.push_back(mk(BL, 32'h0, 1'b1, 1'b0, 1'b0));
    q1.push_back(mk(BL, 32'h0, 1'b1, 1'b1, 1'b0));
  endtask

  task automatic wait_drain(int inst, int budget);
    int n = 0;
    while (((inst == 0) ? q0.size() : q1.size()) > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (((inst == 0) ? q0.size() : q1.size()) > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_u%0d: %0d expected outputs still pending after %0d cycles",
               inst, (inst == 0) ? q0.size() : q1.size(), budget);
      if (inst == 0) q0.delete(); else q1.delete();
    end
  endtask

  // Pixel sources: present the next kernel whenever the DUT requests one.
  initial begin
    pix0 = 32'h0;
    pix1 = 32'h0;
    forever begin
      @(negedge clk);
      if (rdy0 === 1'b1) begin pix0 = pv0(pcnt0); pcnt0++; end
      if (rdy1 === 1'b1) begin pix1 = pv1(pcnt1); pcnt1++; end
    end
  end

  // Monitor: one expected entry per output cycle while a scenario is active.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("u0_out", {sync0, camd0, busy0, fd0, rdy0}, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("u1_out", {sync1, camd1, busy1, fd1, rdy1}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    en0 = 1'b1; st0 = 1'b0;
    en1 = 1'b1; st1 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_u0", {sync0, camd0, busy0, fd0, rdy0}, mk(TP, 32'h0, 1'b0, 1'b0, 1'b0));
    chk("reset_u1", {sync1, camd1, busy1, fd1, rdy1}, mk(TP, 32'h0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q0.push_back(idle(1'b1));
    q1.push_back(idle(1'b1));
    @(negedge clk);

    // Default frame with counter pixel data.
    st0 = 1'b1;
    push_frame0();
    q0.push_back(idle(1'b1));
    @(negedge clk);
    st0 = 1'b0;
    wait_drain(0, 200);

    // Lane-wise checksum on the short instance, two frames back to back.
    st1 = 1'b1;
    push_frame1(32'h1122_3344, 32'h0102_0304, 32'h1020_3040);
    q1.push_back(idle(1'b1));
    @(negedge clk);
    st1 = 1'b0;
    wait_drain(1, 50);
    st1 = 1'b1;
    push_frame1(32'hDEAD_0002, 32'hDEAD_0003, 32'h0000_0001);
    q1.push_back(idle(1'b1));
    @(negedge clk);
    st1 = 1'b0;
    wait_drain(1, 50);

    // start held high: exactly one TP cycle between consecutive frames.
    st0 = 1'b1;
    push_frame0();
    q0.push_back(idle(1'b1));
    push_frame0();
    q0.push_back(idle(1'b1));
    n = 0;
    while (q0.size() > 60 && n < 300) begin
      @(negedge clk);
      n++;
    end
    st0 = 1'b0;
    wait_drain(0, 200);

    // enable low in IDLE: BL output, start ignored.
    en0 = 1'b0;
    st0 = 1'b1;
    repeat (4) begin
      q0.push_back(idle(1'b0));
      @(negedge clk);
    end
    st0 = 1'b0;
    wait_drain(0, 10);

    // enable dropped mid-frame: the frame still completes, then IDLE shows BL.
    en0 = 1'b1;
    st0 = 1'b1;
    push_frame0();
    @(negedge clk);
    st0 = 1'b0;
    repeat (10) @(negedge clk);
    en0 = 1'b0;
    q0.push_back(idle(1'b0));
    wait_drain(0, 200);

    // Reset during line 2 IMG aborts the frame at once.
    en0 = 1'b1;
    q0.push_back(idle(1'b1));
    @(negedge clk);
    st0 = 1'b1;
    push_frame0();
    @(negedge clk);
    st0 = 1'b0;
    n = 0;
    while (q0.size() > 30 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk("midreset_u0", {sync0, camd0, busy0, fd0, rdy0}, mk(TP, 32'h0, 1'b0, 1'b0, 1'b0));
    chk("midreset_u1", {sync1, camd1, busy1, fd1, rdy1}, mk(TP, 32'h0, 1'b0, 1'b0, 1'b0));
    q0.push_back(mk(TP, 32'h0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    ecnt0 = pcnt0;
    q0.push_back(idle(1'b1));
    @(negedge clk);
    st0 = 1'b1;
    push_frame0();
    q0.push_back(idle(1'b1));
    @(negedge clk);
    st0 = 1'b0;
    wait_drain(0, 200);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
